// File: rtl/mcu_sequencer.sv
// Strip sequencer for the convolution mux array: loads N+2 line memories,
// steps the convolution units column by column and drains N results per column.
//
// state | meaning
// IDLE  | waiting for i_Start, counters clear
// LOAD  | accepting pixels into line memory sel at column col
// CONV  | convolution units compute column col
// DRAIN | presenting result sel of column col to the sink

module mcu_sequencer #(
    parameter int N      = 4,
    parameter int COLS   = 16,
    parameter int ADDR_W = $clog2(COLS),
    parameter int SEL_W  = $clog2(N + 2)
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_Start,
    input  logic              i_PixelValid,
    output logic              o_PixelReady,
    output logic              o_MemWe,
    output logic [ADDR_W-1:0] o_MemAddr,
    output logic [1:0]        o_state,
    output logic [1:0]        o_substate,
    output logic [SEL_W-1:0]  o_memSelect,
    output logic              o_ConvEn,
    output logic              o_OutValid,
    input  logic              i_OutReady,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_CONV  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [ADDR_W-1:0] COL_LAST      = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] COL_FILL      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] COL_ONE       = ADDR_W'(1);
    localparam logic [SEL_W-1:0]  SEL_LOAD_LAST = SEL_W'(N + 1);
    localparam logic [SEL_W-1:0]  SEL_RES_LAST  = SEL_W'(N - 1);
    localparam logic [SEL_W-1:0]  SEL_ONE       = SEL_W'(1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] col;
    logic [SEL_W-1:0]  sel;
    logic [1:0]        sub;
    logic              done_q;
    logic [1:0]        sub_next;

    // sub tracks col mod 3 incrementally; it only advances when col does
    assign sub_next = (sub == 2'd2) ? 2'd0 : sub + 2'd1;

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state  <= ST_IDLE;
            col    <= '0;
            sel    <= '0;
            sub    <= 2'd0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // the done cycle still belongs to the finished strip
                    if (i_Start && !done_q) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (i_PixelValid) begin
                        if (sel == SEL_LOAD_LAST) begin
                            sel <= '0;
                            if (col == COL_LAST) begin
                                col   <= '0;
                                state <= ST_CONV;
                            end else begin
                                col <= col + COL_ONE;
                            end
                        end else begin
                            sel <= sel + SEL_ONE;
                        end
                    end
                end
                ST_CONV: begin
                    sel <= '0;
                    if (col < COL_FILL) begin
                        col <= col + COL_ONE;
                        sub <= sub_next;
                    end else begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (i_OutReady) begin
                        if (sel == SEL_RES_LAST) begin
                            sel <= '0;
                            if (col == COL_LAST) begin
                                col    <= '0;
                                sub    <= 2'd0;
                                state  <= ST_IDLE;
                                done_q <= 1'b1;
                            end else begin
                                col   <= col + COL_ONE;
                                sub   <= sub_next;
                                state <= ST_CONV;
                            end
                        end else begin
                            sel <= sel + SEL_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        o_state = 2'd0;
        case (state)
            ST_CONV:  o_state = 2'd1;
            ST_DRAIN: o_state = 2'd2;
            default:  o_state = 2'd0;
        endcase
    end

    assign o_PixelReady = (state == ST_LOAD);
    assign o_MemWe      = i_PixelValid & o_PixelReady;
    assign o_MemAddr    = col;
    assign o_memSelect  = sel;
    assign o_substate   = sub;
    assign o_ConvEn     = (state == ST_CONV);
    assign o_OutValid   = (state == ST_DRAIN);
    assign o_Busy       = (state != ST_IDLE);
    assign o_Done       = done_q;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Bench for mcu_sequencer: a strip-level reference model fills expectation
// queues at start; a negedge monitor pops and compares every transfer.

module tb_mcu_sequencer;

    localparam int N      = 4;
    localparam int COLS   = 5;
    localparam int ADDR_W = $clog2(COLS);
    localparam int SEL_W  = $clog2(N + 2);
    localparam int LAT    = 1 + COLS * (N + 2) + COLS + (COLS - 2) * N;

    logic              i_CLK;
    logic              i_RST;
    logic              i_Start;
    logic              i_PixelValid;
    logic              o_PixelReady;
    logic              o_MemWe;
    logic [ADDR_W-1:0] o_MemAddr;
    logic [1:0]        o_state;
    logic [1:0]        o_substate;
    logic [SEL_W-1:0]  o_memSelect;
    logic              o_ConvEn;
    logic              o_OutValid;
    logic              i_OutReady;
    logic              o_Busy;
    logic              o_Done;

    mcu_sequencer #(.N(N), .COLS(COLS)) dut (
        .i_CLK        (i_CLK),
        .i_RST        (i_RST),
        .i_Start      (i_Start),
        .i_PixelValid (i_PixelValid),
        .o_PixelReady (o_PixelReady),
        .o_MemWe      (o_MemWe),
        .o_MemAddr    (o_MemAddr),
        .o_state      (o_state),
        .o_substate   (o_substate),
        .o_memSelect  (o_memSelect),
        .o_ConvEn     (o_ConvEn),
        .o_OutValid   (o_OutValid),
        .i_OutReady   (i_OutReady),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done)
    );

    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    int wq[$];
    int cq[$];
    int rq[$];
    int exp_strips = 0;
    int lat_check  = 0;
    int start_cyc  = 0;
    int done_count = 0;
    int wr_cnt = 0, conv_cnt = 0, res_cnt = 0, stall_cnt = 0;
    int mode = 0;
    int stall_left = 0;
    bit stall_used = 0;

    bit have_prev = 0;
    bit prev_load_idle = 0, prev_drain_idle = 0;
    int prev_load_key = 0, prev_drain_key = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int hkey(input int a, input int b, input int c, input int d);
        return a * 16777216 + b * 65536 + c * 256 + d;
    endfunction

    function automatic int outs();
        return int'({o_PixelReady, o_MemWe, o_MemAddr, o_state, o_substate,
                     o_memSelect, o_ConvEn, o_OutValid, o_Busy, o_Done});
    endfunction

    // Reference model: what one full strip must produce, in order
    task automatic push_strip();
        for (int c = 0; c < COLS; c++)
            for (int s = 0; s < N + 2; s++) wq.push_back(s * 256 + c);
        for (int c = 0; c < COLS; c++) cq.push_back((c % 3) * 256 + c);
        for (int c = 2; c < COLS; c++)
            for (int s = 0; s < N; s++) rq.push_back(s * 256 + c);
    endtask

    // Handshake driver, changes inputs just after each rising edge
    initial begin
        i_PixelValid = 1'b0;
        i_OutReady   = 1'b0;
        forever begin
            @(posedge i_CLK);
            #1;
            case (mode)
                0: begin i_PixelValid = 1'b1; i_OutReady = 1'b1; end
                1: begin i_PixelValid = !i_PixelValid; i_OutReady = 1'b1; end
                2: begin
                    i_PixelValid = 1'b1;
                    if (stall_left > 0) begin
                        i_OutReady = 1'b0;
                        stall_left--;
                    end else if (!stall_used && o_OutValid && o_memSelect == 2) begin
                        stall_used = 1;
                        stall_left = 6;
                        i_OutReady = 1'b0;
                    end else begin
                        i_OutReady = 1'b1;
                    end
                end
                default: begin
                    i_PixelValid = ($urandom_range(0, 3) != 0);
                    i_OutReady   = ($urandom_range(0, 3) != 0);
                end
            endcase
        end
    end

    // Monitor / scoreboard
    always @(negedge i_CLK) begin
        if (!i_RST) begin
            have_prev = 0;
        end else begin
            check("memwe_decode", int'(o_MemWe), int'(i_PixelValid & o_PixelReady));
            if (have_prev && prev_load_idle)
                check("load_hold", hkey(o_PixelReady, o_state, o_memSelect, o_MemAddr), prev_load_key);
            if (have_prev && prev_drain_idle)
                check("drain_hold", hkey(o_OutValid + 2 * o_ConvEn, o_substate, o_memSelect, o_MemAddr),
                      prev_drain_key);
            if (o_MemWe) begin
                wr_cnt++;
                if (wq.size() == 0) check("unexpected_write", 1, 0);
                else check("write_sel_addr", int'(o_memSelect) * 256 + int'(o_MemAddr), wq.pop_front());
                check("write_state", o_state, 0);
            end
            if (o_ConvEn) begin
                conv_cnt++;
                if (cq.size() == 0) check("unexpected_conv", 1, 0);
                else check("conv_sub_addr", int'(o_substate) * 256 + int'(o_MemAddr), cq.pop_front());
                check("conv_state", o_state, 1);
            end
            if (o_OutValid && i_OutReady) begin
                res_cnt++;
                if (rq.size() == 0) check("unexpected_result", 1, 0);
                else check("result_sel_addr", int'(o_memSelect) * 256 + int'(o_MemAddr), rq.pop_front());
                check("drain_state", o_state, 2);
                check("drain_substate", o_substate, int'(o_MemAddr) % 3);
            end
            if (o_OutValid && !i_OutReady) begin
                stall_cnt++;
                if (mode == 2) check("stall_sel", o_memSelect, 2);
            end
            if (o_Done) begin
                done_count++;
                check("done_expected", int'(exp_strips > 0), 1);
                check("done_queues_empty", wq.size() + cq.size() + rq.size(), 0);
                check("done_busy", o_Busy, 0);
                if (exp_strips > 0) exp_strips--;
                if (lat_check != 0) check("latency", cyc - start_cyc, LAT);
            end
            have_prev       = 1;
            prev_load_idle  = o_PixelReady && !i_PixelValid;
            prev_drain_idle = o_OutValid && !i_OutReady;
            prev_load_key   = hkey(o_PixelReady, o_state, o_memSelect, o_MemAddr);
            prev_drain_key  = hkey(o_OutValid + 2 * o_ConvEn, o_substate, o_memSelect, o_MemAddr);
        end
    end

    task automatic start_strip(input int lat);
        @(posedge i_CLK);
        #1;
        push_strip();
        exp_strips++;
        lat_check = lat;
        wr_cnt = 0; conv_cnt = 0; res_cnt = 0; stall_cnt = 0;
        start_cyc = cyc;
        i_Start = 1'b1;
        @(posedge i_CLK);
        #1;
        i_Start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit start_on_done);
        int dc;
        dc = done_count;
        for (int k = 0; k < budget; k++) begin
            @(negedge i_CLK);
            #1;
            if (done_count != dc) break;
        end
        check("done_seen", done_count - dc, 1);
        if (start_on_done && done_count != dc) begin
            i_Start = 1'b1;
            @(posedge i_CLK);
            #1;
            i_Start = 1'b0;
        end
    endtask

    initial begin
        int dc;
        bit found;
        i_RST   = 1'b0;
        i_Start = 1'b0;
        mode    = 0;

        repeat (3) @(negedge i_CLK);
        check("reset_outputs", outs(), 0);
        #2 i_RST = 1'b1;
        repeat (10) begin
            @(negedge i_CLK);
            check("idle_busy", o_Busy, 0);
        end

        // unstalled strip
        mode = 0;
        start_strip(1);
        wait_done(200, 0);
        check("clean_writes", wr_cnt, COLS * (N + 2));
        check("clean_conv", conv_cnt, COLS);
        check("clean_results", res_cnt, (COLS - 2) * N);

        // source gaps
        mode = 1;
        start_strip(0);
        wait_done(400, 0);
        check("gap_writes", wr_cnt, COLS * (N + 2));

        // sink backpressure
        mode = 2;
        stall_used = 0;
        stall_left = 0;
        start_strip(0);
        wait_done(400, 0);
        check("stall_cycles", stall_cnt, 7);
        check("stall_conv", conv_cnt, COLS);
        check("stall_results", res_cnt, (COLS - 2) * N);

        // random handshakes
        mode = 3;
        repeat (3) begin
            start_strip(0);
            wait_done(1500, 0);
            check("rand_writes", wr_cnt, COLS * (N + 2));
            check("rand_results", res_cnt, (COLS - 2) * N);
        end

        // reset mid-drain at column 3
        mode = 0;
        start_strip(0);
        found = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge i_CLK);
            #1;
            if (o_OutValid && o_MemAddr == 3) begin
                found = 1;
                break;
            end
        end
        check("reached_drain_col3", int'(found), 1);
        #2 i_RST = 1'b0;
        #1 check("midreset_outputs", outs(), 0);
        wq.delete(); cq.delete(); rq.delete();
        exp_strips = 0;
        dc = done_count;
        repeat (3) @(negedge i_CLK);
        #2 i_RST = 1'b1;
        repeat (8) @(negedge i_CLK);
        check("no_done_after_reset", done_count, dc);
        check("idle_after_reset", o_Busy, 0);
        start_strip(1);
        wait_done(200, 0);
        check("post_reset_writes", wr_cnt, COLS * (N + 2));

        // start while busy and during the done cycle
        start_strip(0);
        repeat (5) @(posedge i_CLK);
        #1 i_Start = 1'b1;
        @(posedge i_CLK);
        #1 i_Start = 1'b0;
        wait_done(200, 1);
        check("busy_start_writes", wr_cnt, COLS * (N + 2));
        dc = done_count;
        repeat (10) begin
            @(negedge i_CLK);
            check("stay_idle", int'(o_Busy) + 2 * int'(o_PixelReady), 0);
        end
        check("no_extra_done", done_count, dc);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
